// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type, default width and counter sizing for seq_divider.
package div_pkg;
  localparam int DEF_W = 32;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_w(DEF_W);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 step, shift in a dividend bit, trial subtract, keep or restore.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] sh;
  logic [W+1:0] diff;
  assign sh    = {rem_i, bit_i};
  assign diff  = sh - {2'b0, div_i};
  assign q_o   = ~diff[W+1];
  assign rem_o = q_o ? diff[W:0] : sh[W:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider with valid/ready handshakes.
module seq_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sign,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_w(W);
  state_e state_q, state_d;
  logic [W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, a_q, a_d, b_q, b_d, quot_q, quot_d, rem_q, rem_d;
  logic [W:0] r_q, r_d, step_r;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, dbz_q, dbz_d;
  logic step_q, acc, prep, calc, fix;
  div_step #(.W(W)) u_step (
    .rem_i(r_q),
    .bit_i(a_q[W-1]),
    .div_i(b_q),
    .rem_o(step_r),
    .q_o  (step_q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? PREP : IDLE;
      PREP:    state_d = (dvs_q == '0) ? FIX : CALC;
      CALC:    state_d = (cnt_q == CW'(1)) ? FIX : CALC;
      FIX:     state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  assign acc  = in_valid & in_ready;
  assign prep = state_q == PREP;
  assign calc = state_q == CALC;
  assign fix  = state_q == FIX;
  // a_q holds the dividend magnitude and collects quotient bits as it shifts out
  always_comb begin
    dvd_d  = acc ? dividend : dvd_q;
    dvs_d  = acc ? divisor : dvs_q;
    sgn_d  = acc ? sign : sgn_q;
    a_d    = prep ? ((sgn_q & dvd_q[W-1]) ? -dvd_q : dvd_q) : calc ? {a_q[W-2:0], step_q} : a_q;
    b_d    = prep ? ((sgn_q & dvs_q[W-1]) ? -dvs_q : dvs_q) : b_q;
    r_d    = prep ? '0 : calc ? step_r : r_q;
    cnt_d  = prep ? CW'(W) : calc ? cnt_q - 1'b1 : cnt_q;
    qneg_d = prep ? sgn_q & (dvd_q[W-1] ^ dvs_q[W-1]) : qneg_q;
    rneg_d = prep ? sgn_q & dvd_q[W-1] : rneg_q;
    zero_d = prep ? dvs_q == '0 : zero_q;
    quot_d = fix ? (zero_q ? '1 : qneg_q ? -a_q : a_q) : quot_q;
    rem_d  = fix ? (zero_q ? dvd_q : rneg_q ? -r_q[W-1:0] : r_q[W-1:0]) : rem_q;
    dbz_d  = fix ? zero_q : dbz_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      sgn_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      sgn_q  <= sgn_d;
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors checked against an arithmetic reference model every valid cycle.
module tb_seq_divider;
  logic clk = 0, rst = 1, in_valid = 0, sign = 0, out_ready = 0;
  logic in_ready, out_valid, div_by_zero;
  logic [31:0] dividend = 0, divisor = 0, quotient, remainder;
  logic [31:0] exp_q, exp_r;
  logic exp_z, pend = 0;
  int tests = 0, fails = 0;

  seq_divider #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
    end
  endtask

  function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) return {32'hFFFF_FFFF, a, 1'b1};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r, 1'b0};
  endfunction

  always @(negedge clk) if (!rst) begin
    chk("valid_ready_excl", out_valid & in_ready, 0);
    chk("stale_valid", out_valid & ~pend, 0);
    if (out_valid && pend) begin
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("div_by_zero", div_by_zero, exp_z);
    end
  end

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    int n;
    m = model(s, a, b);
    exp_q = m[64:33];
    exp_r = m[32:1];
    exp_z = m[0];
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_wait", in_ready, 1);
    sign = s; dividend = a; divisor = b; in_valid = 1; pend = 1;
    @(posedge clk); #1;
    in_valid = 0; dividend = $urandom; divisor = $urandom; sign = ~s;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold);
    int n;
    launch(s, a, b);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency", n, lat);
    repeat (hold) begin
      in_valid = 1;
      @(posedge clk); #1;
      chk("busy_in_ready", in_ready, 0);
      chk("held_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; pend = 0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  typedef struct { logic s; logic [31:0] a, b, q, r; logic z; int lat, hold; } vec_t;
  vec_t vecs[10] = '{
    '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0},
    '{1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 5},
    '{1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, 0},
    '{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0},
    '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0},
    '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, 2},
    '{1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2, 3},
    '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 34, 0},
    '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 0},
    '{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34, 0}
  };

  initial begin
    logic [64:0] m;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst = 0;
    #1 chk("rst_in_ready", in_ready, 1);
    foreach (vecs[i]) begin
      m = model(vecs[i].s, vecs[i].a, vecs[i].b);
      chk("model_q", m[64:33], vecs[i].q);
      chk("model_r", m[32:1], vecs[i].r);
      chk("model_z", m[0], vecs[i].z);
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold);
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i == 2) ? 32'd0 : $urandom >> (i * 5);
      run_op(i[0], a, b, (b == 0) ? 2 : 34, 0);
    end
    launch(1'b0, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #2 rst = 1; pend = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk); rst = 0;
    #1 chk("midrst_in_ready", in_ready, 1);
    run_op(1'b0, 32'd9, 32'd3, 34, 0);
    chk("final_quotient", quotient, 3);
    chk("final_remainder", remainder, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, operand and result width W (even, >=4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  divider idle, request accepted when in_valid&in_ready.
REQ-006 SHALL have port: sign  input  1  1 = two's-complement signed operation, 0 = unsigned.
REQ-007 SHALL have port: dividend  input  W  numerator.
REQ-008 SHALL have port: divisor  input  W  denominator.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result when out_valid&out_ready.
REQ-011 SHALL have port: quotient  output  W  result quotient.
REQ-012 SHALL have port: remainder  output  W  result remainder.
REQ-013 SHALL have port: div_by_zero  output  1  result produced with divisor==0.

Function
REQ-014 SHALL implement FSM IDLE, PREP, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE->PREP on accept; operands and sign SHALL be registered at the accepting edge; in_valid SHALL be ignored in all other states.
REQ-016 PREP SHALL form magnitudes (abs when sign=1 and operand MSB=1), record quotient sign = dividend MSB ^ divisor MSB and remainder sign = dividend MSB (signed only); PREP->CALC, or PREP->FIX if divisor==0.
REQ-017 CALC SHALL perform exactly W restoring radix-2 steps, one quotient bit per cycle MSB first, using a W+1-bit partial remainder and a down-counter; CALC->FIX after step W.
REQ-018 FIX SHALL negate quotient/remainder per recorded signs and register results; FIX->DONE.
REQ-019 Latency: out_valid SHALL rise exactly W+2 edges after the accepting edge (34 for W=32); 2 edges for divide-by-zero.
REQ-020 DONE SHALL hold out_valid, quotient, remainder, div_by_zero stable until out_ready=1; DONE->IDLE on that edge; out_valid and in_ready SHALL never both be 1.
REQ-021 Divisor==0: quotient SHALL be all ones, remainder SHALL equal dividend, div_by_zero=1, for both sign modes.
REQ-022 Signed overflow (dividend=-2^(W-1), divisor=-1): quotient SHALL be -2^(W-1), remainder 0, div_by_zero=0.
REQ-023 Signed results SHALL truncate toward zero; remainder sign SHALL equal dividend sign (or be 0).
REQ-024 Throughput: at most one operation per W+3 cycles; no overlap of operations.

Reset
REQ-025 rst=1 at any time, including mid-CALC or in DONE, SHALL asynchronously force IDLE, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0; in-flight operation SHALL be discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-027 Shared package div_pkg SHALL hold the FSM state typedef, default DATA_WIDTH, and counter width constant ($clog2 of W+1).
REQ-028 One sub-module div_step (combinational: shift-in dividend bit, trial subtract, select, emit quotient bit) SHALL be instantiated once inside CALC datapath.

Verification
REQ-029 Unsigned 100/7 -> after 34 cycles quotient=14, remainder=2, div_by_zero=0.
REQ-030 Signed -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); signed 100/-7 -> quotient=-14, remainder=2.
REQ-031 Unsigned 5/0 -> after 2 cycles quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-033 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; accept on out_ready=1 -> in_ready=1 next cycle.
REQ-034 rst pulse at CALC step 10, then new 9/3 -> no stale out_valid, quotient=3, remainder=0 after 34 cycles.
